div_nrest_param: RTL and testbench
==================================

DIV_NREST_PARAM -- requirements
Module: div_nrest_param

Interface
REQ-001 SHALL provide parameter N, default 8, giving the operand/result width in bits (N >= 2).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL provide port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL provide port signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; captured with start.
REQ-006 SHALL provide port dividend  input  N  dividend; captured when start is accepted.
REQ-007 SHALL provide port divisor  input  N  divisor; captured when start is accepted.
REQ-008 SHALL provide port busy  output  1  high from the cycle after start acceptance until done.
REQ-009 SHALL provide port done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 SHALL provide port quotient  output  N  result quotient.
REQ-011 SHALL provide port remainder  output  N  result remainder.
REQ-012 SHALL provide port div_by_zero  output  1  divisor was zero; valid with done.
REQ-013 SHALL provide port ovf  output  1  signed overflow (most-negative / -1); valid with done.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, CORR and DONE.
REQ-015 IDLE SHALL accept start=1 in cycle T and register the operands, mode, N+1-bit accumulator A=0, Q=|dividend|, M=|divisor| and iteration counter=N.
- Magnitudes apply only in signed mode; otherwise raw values are used.
REQ-016 If the captured divisor is 0, the FSM SHALL go IDLE->DONE.
- done SHALL pulse at T+1 with quotient all ones, remainder=dividend, div_by_zero=1.
REQ-017 Otherwise the FSM SHALL go IDLE->RUN, and each RUN cycle SHALL perform one non-restoring step:
- shift {A,Q} left by 1;
- A=A-M if A was non-negative before the shift, else A=A+M;
- Q[0]=~A[N];
- decrement the counter.
REQ-018 After N RUN cycles (T+1..T+N) the FSM SHALL enter CORR at T+N+1.
- If A is negative, A=A+M.
- Signed fixup: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-019 DONE SHALL occur at T+N+2 with done=1 for exactly one cycle, followed by return to IDLE.
REQ-020 The accumulator SHALL be N+1 bits wide, and all add/subtract SHALL be performed modulo 2^(N+1).
REQ-021 In signed mode, dividend = -2^(N-1) with divisor = -1 SHALL produce quotient = 2^(N-1) truncated to N bits, remainder=0 and ovf=1.
- ovf SHALL be 0 in all other cases, including all unsigned divisions.
REQ-022 start SHALL be ignored in RUN, CORR and DONE.
- No queuing; start held high is re-accepted only in the first IDLE cycle after DONE.
REQ-023 quotient, remainder, div_by_zero and ovf SHALL hold their values from done until the next done.
- New operands SHALL NOT disturb them during an operation.
REQ-024 busy SHALL be 1 in RUN, CORR and DONE, and 0 in IDLE.
REQ-025 Operand inputs SHALL be don't-care outside the start-acceptance cycle.

Reset
REQ-026 With rst=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, quotient, remainder, div_by_zero, ovf and the counter SHALL all be 0 on the next cycle.
REQ-027 rst SHALL take priority over start and over any in-progress operation.
- A reset mid-division SHALL abort it with no done pulse.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-029 Bench SHALL cover N=3, unsigned 7/3 (start at T) -> done at T+5, quotient=2, remainder=1, flags 0.
REQ-030 Bench SHALL cover N=8, unsigned 200/7 -> done at T+10, quotient=28, remainder=4, busy high T+1..T+10.
REQ-031 Bench SHALL cover N=8, signed -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1), ovf=0.
REQ-032 Bench SHALL cover N=8, 45/0 -> done at T+1, quotient=0xFF, remainder=45, div_by_zero=1.
REQ-033 Bench SHALL cover N=8, signed -128/-1 -> quotient=0x80, remainder=0, ovf=1.
REQ-034 Bench SHALL cover N=8, start 200/7 then rst at T+4 -> no done, all outputs 0.
- Then 100/9 -> quotient=11, remainder=1.
- start held high throughout -> second operation accepted only after DONE.

Source files
------------

// File: rtl/div_nrest_param.sv
// Sequential non-restoring divider: one quotient bit per cycle, with signed and unsigned modes.
// Divide-by-zero and most-negative/-1 overflow are flagged alongside the result.
module div_nrest_param #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, CORR, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic signed [N:0]    acc;
  logic [N-1:0]         q_reg;
  logic [N-1:0]         m_reg;
  logic                 q_neg;
  logic                 r_neg;
  logic                 ovf_pend;

  logic signed [N:0]    m_ext;
  logic signed [N:0]    acc_sh;
  logic signed [N:0]    acc_nx;
  logic [N-1:0]         rem_mag;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic sm);
    return (sm && v[N-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [N-1:0] cneg(input logic [N-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  // One non-restoring step; the partial remainder stays in [-M, M) so N+1 bits suffice.
  always_comb begin
    m_ext   = {1'b0, m_reg};
    acc_sh  = {acc[N-1:0], q_reg[N-1]};
    acc_nx  = acc[N] ? (acc_sh + m_ext) : (acc_sh - m_ext);
    rem_mag = acc[N] ? (acc[N-1:0] + m_reg) : acc[N-1:0];
  end

  // Datapath registers: no reset, their contents only matter once an operation is accepted.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          acc      <= '0;
          q_reg    <= mag(dividend, signed_mode);
          m_reg    <= mag(divisor, signed_mode);
          q_neg    <= signed_mode & (dividend[N-1] ^ divisor[N-1]);
          r_neg    <= signed_mode & dividend[N-1];
          ovf_pend <= signed_mode && (dividend == MOST_NEG) && (divisor == {N{1'b1}});
        end
      end
      RUN: begin
        acc   <= acc_nx;
        q_reg <= {q_reg[N-2:0], ~acc_nx[N]};
      end
      default: ;
    endcase
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(N);
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              ovf         <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= CORR;
        end
        CORR: begin
          quotient    <= cneg(q_reg, q_neg);
          remainder   <= cneg(rem_mag, r_neg);
          div_by_zero <= 1'b0;
          ovf         <= ovf_pend;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nrest_param.sv
// Scoreboard bench for div_nrest_param at N=8 and N=3 with hand-computed expected results.
module tb_div_nrest_param;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  exp_t q8[$];
  exp_t q3[$];
  exp_t e8;
  exp_t e3;

  logic       d8_start = 1'b0, d8_sm = 1'b0;
  logic [7:0] d8_dvd = '0, d8_dvs = '0;
  logic       d8_busy, d8_done, d8_dz, d8_ovf;
  logic [7:0] d8_quot, d8_rem;

  logic       d3_start = 1'b0, d3_sm = 1'b0;
  logic [2:0] d3_dvd = '0, d3_dvs = '0;
  logic       d3_busy, d3_done, d3_dz, d3_ovf;
  logic [2:0] d3_quot, d3_rem;

  div_nrest_param #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(d8_start), .signed_mode(d8_sm),
    .dividend(d8_dvd), .divisor(d8_dvs), .busy(d8_busy), .done(d8_done),
    .quotient(d8_quot), .remainder(d8_rem), .div_by_zero(d8_dz), .ovf(d8_ovf)
  );

  div_nrest_param #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(d3_start), .signed_mode(d3_sm),
    .dividend(d3_dvd), .divisor(d3_dvs), .busy(d3_busy), .done(d3_done),
    .quotient(d3_quot), .remainder(d3_rem), .div_by_zero(d3_dz), .ovf(d3_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (d8_done === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL d8_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("d8_quotient", int'(d8_quot), int'(e8.q));
        chk("d8_remainder", int'(d8_rem), int'(e8.r));
        chk("d8_div_by_zero", int'(d8_dz), int'(e8.dz));
        chk("d8_ovf", int'(d8_ovf), int'(e8.ov));
        chk("d8_done_cycle", cyc, e8.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (d3_done === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL d3_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e3 = q3.pop_front();
        chk("d3_quotient", int'(d3_quot), int'(e3.q));
        chk("d3_remainder", int'(d3_rem), int'(e3.r));
        chk("d3_div_by_zero", int'(d3_dz), int'(e3.dz));
        chk("d3_ovf", int'(d3_ovf), int'(e3.ov));
        chk("d3_done_cycle", cyc, e3.cyc);
      end
    end
  end

  task automatic push8(input logic [7:0] eq, er, input logic edz, eov, input int lat);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.cyc = cyc + lat;
    q8.push_back(e);
  endtask

  task automatic go8(input logic sm, input logic [7:0] a, b, eq, er, input logic edz, eov);
    d8_start = 1'b1; d8_sm = sm; d8_dvd = a; d8_dvs = b;
    push8(eq, er, edz, eov, edz ? 1 : 10);
    @(posedge clk); #1;
    d8_start = 1'b0;
  endtask

  task automatic go3(input logic sm, input logic [2:0] a, b, eq, er, input logic edz, eov);
    exp_t e;
    d3_start = 1'b1; d3_sm = sm; d3_dvd = a; d3_dvs = b;
    e.q = {5'b0, eq}; e.r = {5'b0, er}; e.dz = edz; e.ov = eov;
    e.cyc = cyc + (edz ? 1 : 5);
    q3.push_back(e);
    @(posedge clk); #1;
    d3_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q8.size() != 0 || q3.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q8.size() != 0 || q3.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got %0d/%0d pending expected 0", q8.size(), q3.size());
      q8.delete();
      q3.delete();
    end
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_busy"}, int'(d8_busy), 0);
    chk({tag, "_done"}, int'(d8_done), 0);
    chk({tag, "_quotient"}, int'(d8_quot), 0);
    chk({tag, "_remainder"}, int'(d8_rem), 0);
    chk({tag, "_div_by_zero"}, int'(d8_dz), 0);
    chk({tag, "_ovf"}, int'(d8_ovf), 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk_zero8("reset8");
    chk("reset3_busy", int'(d3_busy), 0);
    chk("reset3_quotient", int'(d3_quot), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // N=3 vectors
    go3(1'b0, 3'd7, 3'd3, 3'd2, 3'd1, 1'b0, 1'b0);
    wait_idle();
    go3(1'b0, 3'd5, 3'd0, 3'd7, 3'd5, 1'b1, 1'b0);
    wait_idle();
    go3(1'b1, 3'b100, 3'b111, 3'b100, 3'd0, 1'b0, 1'b1);
    wait_idle();
    go3(1'b1, 3'd3, 3'b110, 3'b111, 3'd1, 1'b0, 1'b0);
    wait_idle();

    // N=8 unsigned 200/7 with busy window T+1..T+10
    d8_start = 1'b1; d8_sm = 1'b0; d8_dvd = 8'd200; d8_dvs = 8'd7;
    push8(8'd28, 8'd4, 1'b0, 1'b0, 10);
    chk("busy_T0", int'(d8_busy), 0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) d8_start = 1'b0;
      chk($sformatf("busy_T%0d", i), int'(d8_busy), 1);
    end
    @(posedge clk); #1;
    chk("busy_T11", int'(d8_busy), 0);
    wait_idle();

    go8(1'b1, 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0);
    wait_idle();
    go8(1'b0, 8'd45, 8'd0, 8'hFF, 8'd45, 1'b1, 1'b0);
    wait_idle();
    go8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    wait_idle();
    go8(1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0);
    wait_idle();
    go8(1'b1, 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 1'b0);
    wait_idle();
    go8(1'b1, 8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0, 1'b0);
    wait_idle();
    go8(1'b0, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
    wait_idle();
    go8(1'b0, 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
    wait_idle();

    // Abort mid-division with start held high throughout
    d8_start = 1'b1; d8_sm = 1'b0; d8_dvd = 8'd200; d8_dvs = 8'd7;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero8("abort");
    d8_dvd = 8'd100; d8_dvs = 8'd9;
    k = cyc;
    push8(8'd11, 8'd1, 1'b0, 1'b0, 10);
    repeat (11) @(posedge clk);
    #1;
    chk("held_idle_busy", int'(d8_busy), 0);
    chk("held_idle_cycle", cyc, k + 11);
    push8(8'd11, 8'd1, 1'b0, 1'b0, 10);
    @(posedge clk); #1;
    d8_start = 1'b0;
    d8_dvd = 8'd3; d8_dvs = 8'd2;
    chk("held_second_busy", int'(d8_busy), 1);
    chk("hold_quotient", int'(d8_quot), 11);
    chk("hold_remainder", int'(d8_rem), 1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("final_busy", int'(d8_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
